// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data RAM: processor (P) and host loader (H).
// Optional DMEM_ARB_PPRIO_EN: fixed P priority with H starvation guard instead of round-robin.
module dmem_arbiter #(
  parameter int N            = 32,
  parameter int AW           = 17,
  parameter int DEPTH        = 'h8000,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p_req,
  input  logic          p_we,
  input  logic [AW-1:0] p_addr,
  input  logic [N-1:0]  p_wdata,
  output logic [N-1:0]  p_rdata,
  output logic          p_ack,
  output logic          p_err,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [N-1:0]  h_wdata,
  output logic [N-1:0]  h_rdata,
  output logic          h_ack,
  output logic          h_err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [N-1:0]  mem_wdata,
  input  logic [N-1:0]  mem_rdata,
  output logic          owner
);

  typedef enum logic [1:0] {ARB, MEM, RESP} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t        state;
  logic          last;
  logic          oor;
  logic          grant_h;
  logic          sel_we;
  logic          sel_oor;
  logic [AW-1:0] sel_addr;
  logic [N-1:0]  sel_wdata;

`ifdef DMEM_ARB_PPRIO_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_L = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;

  // Counts ARB cycles in which H asked and P took the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!h_req) begin
      starve_cnt <= '0;
    end else if (state == ARB) begin
      if (grant_h)
        starve_cnt <= '0;
      else if (p_req && (starve_cnt != LIMIT_L))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    grant_h = 1'b0;
    if (p_req && h_req) begin
`ifdef DMEM_ARB_PPRIO_EN
      grant_h = (starve_cnt == LIMIT_L);
`else
      grant_h = ~last;
`endif
    end else begin
      grant_h = h_req;
    end
  end

  always_comb begin
    sel_we    = grant_h ? h_we    : p_we;
    sel_addr  = grant_h ? h_addr  : p_addr;
    sel_wdata = grant_h ? h_wdata : p_wdata;
    sel_oor   = ({1'b0, sel_addr} >= DEPTH_L);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      owner     <= 1'b0;
      last      <= 1'b1;
      oor       <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          if (p_req || h_req) begin
            owner     <= grant_h;
            last      <= grant_h;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_we    <= sel_we & ~sel_oor;
            oor       <= sel_oor;
            state     <= MEM;
          end
        end
        MEM: begin
          mem_we <= 1'b0;
          state  <= RESP;
        end
        RESP:    state <= ARB;
        default: state <= ARB;
      endcase
    end
  end

  // Response is decoded from state so the ack lands exactly in the RAM's data cycle.
  always_comb begin
    p_ack   = 1'b0;
    p_err   = 1'b0;
    p_rdata = '0;
    h_ack   = 1'b0;
    h_err   = 1'b0;
    h_rdata = '0;
    if (state == RESP) begin
      if (owner) begin
        h_ack   = 1'b1;
        h_err   = oor;
        h_rdata = oor ? '0 : mem_rdata;
      end else begin
        p_ack   = 1'b1;
        p_err   = oor;
        p_rdata = oor ? '0 : mem_rdata;
      end
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the processor data port (P) and the host loader/unloader port (H). H writes encrypted input words and reads decrypted result words.
- Sits between the address-decode stage and the synchronous data RAM. Owns the RAM address, write-enable and write-data pins.
- Each requester issues one word access per request/ack handshake. Conflicts are resolved round-robin.

Parameters:
- N, 32, data width in bits
- AW, 17, word address width
- DEPTH, 'h8000, number of implemented words; valid word addresses are 0..DEPTH-1
- STARVE_LIMIT, 8, consecutive lost arbitrations before H is forced (optional feature only)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- p_req  in  1  processor access request, level
- p_we  in  1  1 = write, 0 = read
- p_addr  in  AW  processor word address
- p_wdata  in  N  processor write data
- p_rdata  out  N  read data, valid while p_ack=1
- p_ack  out  1  one-cycle completion pulse
- p_err  out  1  one-cycle pulse with p_ack when address >= DEPTH
- h_req, h_we, h_addr, h_wdata, h_rdata, h_ack, h_err  same as P-group, host side
- mem_addr  out  AW  RAM word address, registered
- mem_we  out  1  RAM write enable, registered
- mem_wdata  out  N  RAM write data, registered
- mem_rdata  in  N  RAM read data; 1-cycle latency after the address edge
- owner  out  1  0 = P, 1 = H; last granted requester

Behaviour:
- Reset (rst_n low, asynchronous): state=ARB, mem_we=0, mem_addr=0, mem_wdata=0, owner=0, last=1 (so P wins the first conflict), all ack/err=0, rdata outputs=0. Reset applied in MEM or RESP abandons the access with no ack; a write in flight may or may not land.
- FSM: ARB -> MEM -> RESP -> ARB.
- ARB: sample p_req/h_req.
  - None: stay in ARB.
  - One requesting: that requester wins.
  - Both requesting: winner = !last.
  - At the edge: latch owner and last, load mem_addr and mem_wdata from the winner, mem_we = winner_we AND (addr < DEPTH), latch oor = (addr >= DEPTH), go to MEM.
- MEM: mem_* held stable; RAM samples at the end edge. At the edge: mem_we cleared to 0, go to RESP.
- RESP: owner's ack=1 (combinational from state/owner).
  - Owner rdata = mem_rdata, or 0 when oor=1.
  - Owner err = oor.
  - Non-owner ack/err/rdata = 0.
  - Go to ARB.
- Latency: request sampled in ARB at cycle T -> ack at cycle T+2. Throughput: one access per 3 cycles.
- Requester rule: hold req and fields stable until the ack edge. Keep req high afterwards only for a new access with updated fields.
- Requests arriving during MEM/RESP wait for ARB. No queuing and no reordering.
- Out-of-range access: RAM is never written, mem_addr still loaded, mem_rdata ignored.
- A write followed by a read to the same address (either port) returns the new data, because the accesses are strictly serialized.
- mem_addr holds its last value between accesses.

Optional Feature:
- Macro DMEM_ARB_PPRIO_EN.
- Defined:
  - P has fixed priority on conflict.
  - A counter increments each ARB cycle in which H requests and loses. It resets to 0 when H is granted or h_req is low.
  - When counter == STARVE_LIMIT, H wins the next conflict.
- Undefined: pure round-robin as above. No counter is synthesized and STARVE_LIMIT is unused.

Test Plan:
- Reset, then P reads addr 5 (RAM preloaded with 'hA5A5) -> p_ack at T+2, p_rdata='hA5A5, p_err=0, h_ack=0 throughout.
- H writes 'h1234 to addr 'h100, then P reads 'h100 -> mem_we high exactly one cycle; p_rdata='h1234.
- P and H both hold req high for 6 accesses -> grants alternate P,H,P,H,P,H; owner toggles; each ack 3 cycles apart.
- H write to addr DEPTH -> mem_we stays 0, h_ack and h_err pulse together, h_rdata=0, RAM unchanged.
- P write issued, rst_n pulled low during MEM -> all outputs return to reset values immediately, no ack; the next access after reset completes normally.
- With DMEM_ARB_PPRIO_EN and both requesting continuously -> 8 P grants, then 1 H grant, repeating. Without the macro -> alternation.
